// File: rtl/softcore_top_nios2_gen2_0_cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave.
// Accepts one command (IR + DR word), walks UIR/CDR/SDR*DR_WIDTH/UDR/RTI
// on the vji_* strobes with a divided tck, and returns the DR word seen on tdo.
// Optional feature macro: DEBUG_SCAN_IR_CACHE_EN (skip UIR when the IR repeats).
module softcore_top_nios2_gen2_0_cpu_debug_scan_master #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;

    // period counter must hold DR_WIDTH-1 and RTI_CYCLES-1 (<= 14)
    localparam int PW = ($clog2(DR_WIDTH) > 4) ? $clog2(DR_WIDTH) : 4;

    state_t                state_q;
    state_t                nxt_st;
    state_t                start_st;
    logic [7:0]            div_q;
    logic                  tck_q;
    logic [PW-1:0]         per_q;
    logic [PW-1:0]         nxt_per;
    logic [DR_WIDTH-1:0]   dat_q;
    logic [DR_WIDTH-1:0]   cap_q;
    logic [DR_WIDTH-1:0]   rsp_data_q;
    logic                  rsp_valid_q;
    logic                  cmd_ready_q;
    logic                  tdi_q;
    logic [IR_WIDTH-1:0]   ir_in_q;
    logic [IR_WIDTH-1:0]   ir_status_q;
    logic                  uir_q, cdr_q, sdr_q, udr_q, rti_q;
`ifdef DEBUG_SCAN_IR_CACHE_EN
    logic [IR_WIDTH-1:0]   last_ir_q;
    logic                  irv_q;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_rti   = rti_q;

    // first scan state after accept: UIR unless the cached IR matches
    always_comb begin
        start_st = UIR;
`ifdef DEBUG_SCAN_IR_CACHE_EN
        if (irv_q && (cmd_ir == last_ir_q)) start_st = CDR;
`endif
    end

    // state and period count for the next tck period
    always_comb begin
        nxt_st  = state_q;
        nxt_per = '0;
        case (state_q)
            UIR: nxt_st = CDR;
            CDR: nxt_st = SDR;
            SDR: begin
                if (per_q == PW'(DR_WIDTH - 1)) nxt_st = UDR;
                else                            nxt_per = per_q + 1'b1;
            end
            UDR: nxt_st = RTI;
            RTI: begin
                if (per_q == PW'(RTI_CYCLES - 1)) nxt_st = RSP;
                else                              nxt_per = per_q + 1'b1;
            end
            default: nxt_st = state_q;
        endcase
    end

    // scan sequencer: tck divider, shift/capture and registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            tck_q       <= 1'b0;
            per_q       <= '0;
            dat_q       <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            tdi_q       <= 1'b0;
            ir_in_q     <= '0;
            ir_status_q <= '0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
`ifdef DEBUG_SCAN_IR_CACHE_EN
            last_ir_q   <= '0;
            irv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= start_st;
                        cmd_ready_q <= 1'b0;
                        dat_q       <= cmd_data;
                        div_q       <= '0;
                        tck_q       <= 1'b0;
                        per_q       <= '0;
                        uir_q       <= (start_st == UIR);
                        cdr_q       <= (start_st == CDR);
                        if (start_st == UIR) ir_in_q <= cmd_ir;
`ifdef DEBUG_SCAN_IR_CACHE_EN
                        last_ir_q   <= cmd_ir;
                        irv_q       <= 1'b1;
`endif
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (div_q == 8'(TCK_DIV - 1)) begin
                        div_q <= '0;
                        tck_q <= ~tck_q;
                        if (!tck_q) begin
                            // rising tck: sample ahead of the slave's shift
                            if (state_q == SDR) cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
                            if (state_q == UIR) ir_status_q <= vji_ir_out;
                        end else begin
                            // falling tck: start of the next period
                            state_q <= nxt_st;
                            per_q   <= nxt_per;
                            uir_q   <= 1'b0;
                            cdr_q   <= (nxt_st == CDR);
                            sdr_q   <= (nxt_st == SDR);
                            udr_q   <= (nxt_st == UDR);
                            rti_q   <= (nxt_st == RTI);
                            if (nxt_st == SDR) begin
                                tdi_q <= dat_q[0];
                                dat_q <= dat_q >> 1;
                            end else begin
                                tdi_q <= 1'b0;
                            end
                            if (nxt_st == RSP) begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= cap_q;
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softcore_top_nios2_gen2_0_cpu_debug_scan_master.sv
// Directed bench: default-parameter instance with a loopback slave and a
// scoreboard queue, plus a small TCK_DIV=1 / DR_WIDTH=8 / RTI_CYCLES=3 instance.
module tb_softcore_top_nios2_gen2_0_cpu_debug_scan_master;
    localparam int DW = 38;
`ifdef DEBUG_SCAN_IR_CACHE_EN
    localparam int HIT_LAT = 164;
    localparam int HIT_UIR = 0;
`else
    localparam int HIT_LAT = 168;
    localparam int HIT_UIR = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // instance A: defaults
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic tck, tdi, tdo, uir, cdr, sdr, udr, rti;
    logic [1:0] cmd_ir, ir_in, ir_out;
    logic [DW-1:0] cmd_data, rsp_data;

    softcore_top_nios2_gen2_0_cpu_debug_scan_master dut_a (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
        .vji_ir_in(ir_in), .vji_ir_out(ir_out), .vji_uir(uir), .vji_cdr(cdr),
        .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti));

    // loopback slave A
    logic [DW-1:0] sreg, preload, udr_seen;
    assign tdo    = sreg[0];
    assign ir_out = ir_in;
    always @(posedge tck) begin
        if (cdr)      sreg <= preload;
        else if (sdr) sreg <= {tdi, sreg[DW-1:1]};
        if (udr) udr_seen <= sreg;
    end

    // instance B: TCK_DIV=1, DR_WIDTH=8, RTI_CYCLES=3
    logic b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
    logic b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;
    logic [1:0] b_cmd_ir, b_ir_in, b_ir_out;
    logic [7:0] b_cmd_data, b_rsp_data, b_sreg, b_preload, b_udr_seen;

    softcore_top_nios2_gen2_0_cpu_debug_scan_master #(
        .DR_WIDTH(8), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
        .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out), .vji_uir(b_uir), .vji_cdr(b_cdr),
        .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti));

    assign b_tdo    = b_sreg[0];
    assign b_ir_out = b_ir_in;
    always @(posedge b_tck) begin
        if (b_cdr)      b_sreg <= b_preload;
        else if (b_sdr) b_sreg <= {b_tdi, b_sreg[7:1]};
        if (b_udr) b_udr_seen <= b_sreg;
    end

    // strobe/tdi/ir monitor on instance A
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    int n_multi = 0, n_irbad = 0, n_tdibad = 0;
    logic ptck = 1'b0;
    logic [1:0] exp_ir = 2'b00;
    always @(negedge clk) begin
        if (tck && !ptck) begin
            n_uir += int'(uir); n_cdr += int'(cdr); n_sdr += int'(sdr);
            n_udr += int'(udr); n_rti += int'(rti);
        end
        ptck = tck;
        if ($countones({uir, cdr, sdr, udr, rti}) > 1) n_multi++;
        if ((uir || cdr || sdr || udr || rti) && ir_in !== exp_ir) n_irbad++;
        if (!sdr && tdi) n_tdibad++;
    end

    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] pre, d;
        int lat, nuir, s_uir, s_cdr, s_sdr, s_udr, s_rti;
        time t;
    } exp_t;
    exp_t q[$];

    task automatic drive(input logic [1:0] ir, input logic [DW-1:0] d, input logic [DW-1:0] pre);
        @(negedge clk);
        cmd_ir = ir; cmd_data = d; preload = pre; cmd_valid = 1'b1;
    endtask

    // waits (from a negedge) for the accept edge and records the expectation
    task automatic accept(input logic [1:0] ir, input logic [DW-1:0] d, input logic [DW-1:0] pre,
                          input int lat, input int nuir, input bit push, output int waited);
        exp_t e;
        int w = 0;
        while (!cmd_ready && w < 400) begin @(negedge clk); w++; end
        waited = w;
        if (!cmd_ready) begin
            chk("accept_timeout", 64'(0), 64'(1));
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_ir = ir;
        if (push) begin
            e.pre = pre; e.d = d; e.lat = lat; e.nuir = nuir; e.t = $time;
            e.s_uir = n_uir; e.s_cdr = n_cdr; e.s_sdr = n_sdr; e.s_udr = n_udr; e.s_rti = n_rti;
            q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = ~d; cmd_ir = ~ir;
    endtask

    task automatic recv();
        exp_t e;
        int w = 0;
        while (!rsp_valid && w < 1000) begin @(negedge clk); w++; end
        if (q.size() == 0) begin chk("queue_empty", 64'(0), 64'(1)); return; end
        e = q.pop_front();
        if (!rsp_valid) begin chk("rsp_timeout", 64'(0), 64'(1)); return; end
        chk("latency",  64'(($time - 5 - e.t) / 10), 64'(e.lat));
        chk("rsp_data", 64'(rsp_data), 64'(e.pre));
        chk("slave_dr", 64'(udr_seen), 64'(e.d));
        chk("n_uir", 64'(n_uir - e.s_uir), 64'(e.nuir));
        chk("n_cdr", 64'(n_cdr - e.s_cdr), 64'(1));
        chk("n_sdr", 64'(n_sdr - e.s_sdr), 64'(DW));
        chk("n_udr", 64'(n_udr - e.s_udr), 64'(1));
        chk("n_rti", 64'(n_rti - e.s_rti), 64'(1));
    endtask

    initial begin
        int w, hb, s, nt, hi;
        logic prev;
        logic [DW-1:0] cap;
        time tb0;
        cmd_valid = 0; rsp_ready = 1; cmd_ir = 0; cmd_data = 0; preload = 0;
        b_cmd_valid = 0; b_rsp_ready = 1; b_cmd_ir = 0; b_cmd_data = 0; b_preload = 0;
        #1 reset_n = 1'b0;
        #11;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_outs", 64'({rsp_valid, rsp_data, tck, tdi, ir_in, uir, cdr, sdr, udr, rti}), 64'(0));
        chk("rst_b", 64'({b_cmd_ready, b_rsp_valid, b_tck, b_uir, b_cdr, b_sdr, b_udr, b_rti}), 64'h80);
        @(negedge clk); reset_n = 1'b1;

        // abort mid-SDR at bit 10
        drive(2'b01, 38'h00_1234_5678, 38'h3F_FFFF_FFFF);
        accept(2'b01, 38'h00_1234_5678, 38'h3F_FFFF_FFFF, 168, 1, 1'b0, w);
        s = n_sdr; w = 0;
        while (n_sdr - s < 11 && w < 1000) begin @(negedge clk); w++; end
        chk("reached_bit10", 64'(n_sdr - s), 64'(11));
        #2 reset_n = 1'b0;
        #1;
        chk("abort_outs", 64'({rsp_valid, rsp_data, tck, tdi, ir_in, uir, cdr, sdr, udr, rti}), 64'(0));
        chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk); reset_n = 1'b1;
        hb = 0;
        repeat (10) begin
            @(negedge clk);
            if (tck !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) hb++;
        end
        chk("post_abort_idle", 64'(hb), 64'(0));

        // main loopback scan, then repeated IR, then IR change
        drive(2'b01, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0);
        accept(2'b01, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 168, 1, 1'b1, w);
        recv();
        drive(2'b10, 38'h01_8000_0001, 38'h20_0000_0003);
        accept(2'b10, 38'h01_8000_0001, 38'h20_0000_0003, 168, 1, 1'b1, w);
        recv();
        drive(2'b10, 38'h3C_DEAD_BEEF, 38'h03_CAFE_F00D);
        accept(2'b10, 38'h3C_DEAD_BEEF, 38'h03_CAFE_F00D, HIT_LAT, HIT_UIR, 1'b1, w);
        recv();
        drive(2'b11, 38'h12_3456_789A, 38'h2E_DCBA_9876);
        rsp_ready = 1'b0;
        accept(2'b11, 38'h12_3456_789A, 38'h2E_DCBA_9876, 168, 1, 1'b1, w);
        recv();

        // back-pressure with the next command already pending
        cap = rsp_data;
        cmd_ir = 2'b01; cmd_data = 38'h0F_F00F_F00F; preload = 38'h30_0FF0_0FF0; cmd_valid = 1'b1;
        hb = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_data !== cap || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) hb++;
        end
        chk("hold_stable", 64'(hb), 64'(0));
        rsp_ready = 1'b1;
        accept(2'b01, 38'h0F_F00F_F00F, 38'h30_0FF0_0FF0, 168, 1, 1'b1, w);
        chk("b2b_wait", 64'(w), 64'(1));
        chk("b2b_uir", 64'({uir, cmd_ready}), 64'(2'b10));
        recv();

        chk("never_multi_strobe", 64'(n_multi), 64'(0));
        chk("ir_in_held", 64'(n_irbad), 64'(0));
        chk("tdi_outside_sdr", 64'(n_tdibad), 64'(0));
        chk("queue_drained", 64'(q.size()), 64'(0));

        // instance B
        @(negedge clk);
        chk("b_ready", 64'(b_cmd_ready), 64'(1));
        b_cmd_ir = 2'b01; b_cmd_data = 8'hA5; b_preload = 8'h3C; b_cmd_valid = 1'b1;
        @(posedge clk); tb0 = $time;
        @(negedge clk); b_cmd_valid = 1'b0;
        prev = 1'b1; nt = 0; hi = 0; w = 0;
        while (!b_rsp_valid && w < 200) begin
            if (b_tck === prev) nt++;
            if (b_tck) hi++;
            prev = b_tck;
            @(negedge clk); w++;
        end
        chk("b_latency", 64'(($time - 5 - tb0) / 10), 64'(28));
        chk("b_rsp_data", 64'(b_rsp_data), 64'(8'h3C));
        chk("b_slave_dr", 64'(b_udr_seen), 64'(8'hA5));
        chk("b_tck_toggle", 64'(nt), 64'(0));
        chk("b_periods", 64'(hi), 64'(14));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/softcore_top_nios2_gen2_0_cpu_debug_scan_master.md
Name: softcore_top_nios2_gen2_0_cpu_debug_scan_master

Overview:
- Scan initiator that drives the virtual-JTAG side of the Nios II debug slave from the system clock domain.
- Takes one command (IR value + DR word), then sequences UIR, CDR, SDR×DR_WIDTH, UDR and RTI on the vji_* signals with a generated tck.
- Returns the DR word shifted out on tdo.
- Used as the in-fabric debug host and as the bench driver that replaces the tied-off vji_* stubs.

Parameters:
- DR_WIDTH, 38, debug data-register length in bits.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per tck half-period; legal range 1..255.
- RTI_CYCLES, 1, tck periods spent in run-test-idle after UDR; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block is in IDLE with no response pending.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_data  in  DR_WIDTH  DR word to shift in.
- rsp_valid  out  1  captured word valid.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_WIDTH  word shifted out of tdo.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  IR presented to slave.
- vji_ir_out  in  IR_WIDTH  slave IR status; captured into ir_status on UIR.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset:
  - All outputs are 0, except cmd_ready, which is 1.
  - State is IDLE, tck is low and all counters are cleared.
  - Reset asserted mid-scan aborts immediately; no partial response is produced.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_data and cmd_ir are latched on acceptance and are don't-care afterwards.
- tck period:
  - One period is a low half of TCK_DIV clk cycles followed by a high half of TCK_DIV clk cycles.
  - tck is held low in IDLE and RSP.
  - State, strobes, tdi and ir_in change only on the clk edge that starts a low half.
  - tdo is sampled on the clk edge that drives tck high, i.e. before the slave's posedge shift.
- States (each lasts whole tck periods):
  - IDLE → UIR on accept.
  - UIR: 1 period; vji_uir=1; vji_ir_in=cmd_ir, which is held until the next UIR. → CDR.
  - CDR: 1 period; vji_cdr=1. → SDR.
  - SDR: DR_WIDTH periods; vji_sdr=1.
    - tdi = data bit k in period k, LSB first.
    - The tdo sample is shifted into the capture register MSB-side, right shift.
    - After the last bit, capture[0] is the first bit out. → UDR.
  - UDR: 1 period; vji_udr=1. → RTI.
  - RTI: RTI_CYCLES periods; vji_rti=1. → RSP.
  - RSP: rsp_valid=1 and rsp_data=capture, both stable until rsp_ready is sampled high; then → IDLE the next cycle.
- Strobes are mutually exclusive (one-hot or all zero).
- vji_tdi=0 outside SDR.
- Latency from the accept edge to rsp_valid high: (4+DR_WIDTH+RTI_CYCLES−1)·2·TCK_DIV clk cycles, which is 168 for the defaults.
- cmd_valid while busy: the command is held off (cmd_ready=0) and is never dropped.
- rsp_ready high while rsp_valid low is ignored.
- A back-to-back command is accepted no earlier than the cycle after the response handshake.

Optional Feature:
- DEBUG_SCAN_IR_CACHE_EN defined:
  - The block keeps last_ir and a valid flag; the flag is cleared by reset.
  - If the flag is set and cmd_ir == last_ir, the UIR period is skipped: IDLE → CDR, and latency drops by 2·TCK_DIV.
- Undefined: UIR is issued for every command.

Test Plan:
- Reset mid-SDR (bit 10): all outputs 0 within 0 cycles of reset_n low; after release, cmd_ready=1 and vji_tck stays low until the next accept.
- Defaults, with a bench slave loopback register preloaded at CDR with 38'h15_0F0F_F0F0; cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA → rsp_data=38'h15_0F0F_F0F0, slave register holds 38'h2A_5555_AAAA at UDR, rsp_valid exactly 168 cycles after accept.
- Strobe sequence check → uir×1, cdr×1, sdr×38, udr×1, rti×1 periods, never two strobes high together, ir_in=2'b01 from UIR onward.
- Hold rsp_ready=0 for 20 cycles while cmd_valid stays high → rsp_data stable, cmd_ready=0; second command accepted one cycle after the handshake.
- TCK_DIV=1, DR_WIDTH=8, RTI_CYCLES=3, cmd_data=8'hA5 with loopback → tck period 2 clk, capture=preload, latency (4+8+2)·2=28.
- DEBUG_SCAN_IR_CACHE_EN, two commands with cmd_ir=2'b10 → second has no UIR pulse and latency 164; a third command with cmd_ir=2'b11 restores the UIR pulse.
